// File: rtl/edge_stim_gen_pkg.sv
// ---------------------------------------------------------------------------
// edge_stim_gen_pkg
//   Shared definitions for the edge stimulus generator:
//     - state_t      : run-control FSM states
//     - LATCH/POS/NEG: bit positions of the D-latch, posedge FF and negedge FF
//                      inside both the q readback and the exp model vector
//     - sat_inc8     : saturating increment for the 8-bit error counter
// ---------------------------------------------------------------------------
package edge_stim_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int unsigned LATCH = 2;
    localparam int unsigned POS   = 1;
    localparam int unsigned NEG   = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/edge_stim_gen_phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
//   Divides clk into half-phases of DIV cycles and counts PHASES half-phases.
//   Ports:
//     i_clk          system clock
//     i_rst_n        synchronous active-low reset
//     i_clear        restart at cycle 0 of half-phase 0
//     i_run          advance the cycle counter
//     o_phase        current half-phase index
//     o_mid          cycle DIV/2-1 of the half-phase (anything registered here
//                    becomes visible on cycle DIV/2)
//     o_last         cycle DIV-1 of the half-phase
//     o_final_phase  current half-phase is the last one of the run
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int unsigned DIV    = 4,
    parameter int unsigned PHASES = 16,
    localparam int unsigned CW    = $clog2(DIV),
    localparam int unsigned PW    = $clog2(PHASES)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_run,
    output logic [PW-1:0] o_phase,
    output logic          o_mid,
    output logic          o_last,
    output logic          o_final_phase
);

    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_phase;

    assign o_phase       = r_phase;
    assign o_mid         = (r_cnt == CW'(DIV / 2 - 1));
    assign o_last        = (r_cnt == CW'(DIV - 1));
    assign o_final_phase = (r_phase == PW'(PHASES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= '0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_phase <= '0;
        end else if (i_run) begin
            if (o_last) begin
                r_cnt   <= '0;
                r_phase <= o_final_phase ? '0 : r_phase + PW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/edge_stim_gen.sv
// ---------------------------------------------------------------------------
// edge_stim_gen
//   Drives a test clock/data pair into a small storage-element DUT (D-latch,
//   posedge FF, negedge FF), keeps a model of what those elements must hold,
//   and counts readback mismatches on the last cycle of every half-phase.
//   Ports:
//     clk      system clock (rising edge)
//     rst_n    synchronous active-low reset
//     start    run request, accepted only in IDLE
//     pattern  PAT_W stimulus bits, captured on an accepted start
//     q        DUT readback {latch, posedge FF, negedge FF}
//     tclk     generated test clock
//     d        generated test data
//     exp      expected value of q, same bit order
//     busy     run in progress
//     done     one-cycle end-of-run pulse
//     err_cnt  saturating mismatch count of the current/last run
// ---------------------------------------------------------------------------
module edge_stim_gen
    import edge_stim_gen_pkg::*;
#(
    parameter int unsigned DIV   = 4,
    parameter int unsigned PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [2:0]       q,
    output logic             tclk,
    output logic             d,
    output logic [2:0]       exp,
    output logic             busy,
    output logic             done,
    output logic [7:0]       err_cnt
);

    localparam int unsigned PHASES = 2 * PAT_W;
    localparam int unsigned PW     = $clog2(PHASES);

    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic             r_tclk;
    logic             r_d;
    logic [2:0]       r_exp;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_err;

    logic             w_accept;
    logic             w_run;
    logic [PW-1:0]    w_phase;
    logic [PW-1:0]    w_idx;
    logic [PAT_W-1:0] w_shift;
    logic             w_bit;
    logic             w_mid;
    logic             w_last;
    logic             w_final;
    logic             w_tclk_nxt;
    logic             w_d_nxt;
    logic [2:0]       w_exp_nxt;
    logic             w_mismatch;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_run    = (r_state == ST_RUN);

    phase_timer #(
        .DIV    (DIV),
        .PHASES (PHASES)
    ) u_timer (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_clear       (w_accept),
        .i_run         (w_run),
        .o_phase       (w_phase),
        .o_mid         (w_mid),
        .o_last        (w_last),
        .o_final_phase (w_final)
    );

    // There are twice as many half-phases as pattern bits; the second pass
    // wraps back over the pattern from bit 0.
    assign w_idx   = (w_phase >= PW'(PAT_W)) ? w_phase - PW'(PAT_W) : w_phase;
    assign w_shift = r_pat >> w_idx;
    assign w_bit   = w_shift[0];

    // Next tclk/d are formed combinationally so the model can be advanced
    // against the same values that will be registered on this edge.
    always_comb begin
        w_tclk_nxt = r_tclk;
        w_d_nxt    = r_d;
        if (w_last) begin
            w_tclk_nxt = w_final ? 1'b0 : ~r_tclk;
        end
        if (w_mid) begin
            w_d_nxt = w_bit;
        end
    end

    always_comb begin
        w_exp_nxt = r_exp;
        if (w_tclk_nxt) begin
            w_exp_nxt[LATCH] = w_d_nxt;
        end
        if (!r_tclk && w_tclk_nxt) begin
            w_exp_nxt[POS] = w_d_nxt;
        end
        if (r_tclk && !w_tclk_nxt) begin
            w_exp_nxt[NEG] = w_d_nxt;
        end
    end

    assign w_mismatch = w_run && w_last && (q != r_exp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pat   <= '0;
            r_tclk  <= 1'b0;
            r_d     <= 1'b0;
            r_exp   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pat   <= pattern;
                        r_err   <= '0;
                        r_busy  <= 1'b1;
                        r_tclk  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_tclk <= w_tclk_nxt;
                    r_d    <= w_d_nxt;
                    r_exp  <= w_exp_nxt;
                    if (w_mismatch) begin
                        r_err <= sat_inc8(r_err);
                    end
                    if (w_last && w_final) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tclk    = r_tclk;
    assign d       = r_d;
    assign exp     = r_exp;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err_cnt = r_err;

endmodule

// File: tb/tb_edge_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_edge_stim_gen
//   Three instances: A (DIV=4, PAT_W=8) checked every cycle against a
//   cycle-index model and by literals; B (DIV=2, PAT_W=8) and C (DIV=2,
//   PAT_W=256) driven with q = ~exp and checked by literals.
// ---------------------------------------------------------------------------
module tb_edge_stim_gen;

    localparam int unsigned DIV_A = 4;
    localparam int unsigned PW_A  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n   = 1'b0;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic         start_c = 1'b0;
    logic [7:0]   pat_a   = '0;
    logic [7:0]   pat_b   = '0;
    logic [255:0] pat_c   = '0;
    logic [2:0]   q_a, q_b, q_c;
    logic         tclk_a, d_a, busy_a, done_a;
    logic         tclk_b, d_b, busy_b, done_b;
    logic         tclk_c, d_c, busy_c, done_c;
    logic [2:0]   exp_a, exp_b, exp_c;
    logic [7:0]   err_a, err_b, err_c;

    int n_checks = 0;
    int n_errors = 0;
    int q_mode_a = 0;     // 0: ideal storage elements, 1: q stuck at 0
    int done_cnt_a = 0;

    edge_stim_gen #(.DIV(DIV_A), .PAT_W(PW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pattern(pat_a), .q(q_a),
        .tclk(tclk_a), .d(d_a), .exp(exp_a), .busy(busy_a), .done(done_a),
        .err_cnt(err_a)
    );

    edge_stim_gen #(.DIV(2), .PAT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pattern(pat_b), .q(q_b),
        .tclk(tclk_b), .d(d_b), .exp(exp_b), .busy(busy_b), .done(done_b),
        .err_cnt(err_b)
    );

    edge_stim_gen #(.DIV(2), .PAT_W(256)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .pattern(pat_c), .q(q_c),
        .tclk(tclk_c), .d(d_c), .exp(exp_c), .busy(busy_c), .done(done_c),
        .err_cnt(err_c)
    );

    // Ideal storage elements clocked by the generated tclk
    logic ff_lat, ff_pos, ff_neg;
    always_latch begin
        if (!rst_n)      ff_lat <= 1'b0;
        else if (tclk_a) ff_lat <= d_a;
    end
    always_ff @(posedge tclk_a or negedge rst_n) begin
        if (!rst_n) ff_pos <= 1'b0;
        else        ff_pos <= d_a;
    end
    always_ff @(negedge tclk_a or negedge rst_n) begin
        if (!rst_n) ff_neg <= 1'b0;
        else        ff_neg <= d_a;
    end

    assign q_a = (q_mode_a == 1) ? 3'b000 : {ff_lat, ff_pos, ff_neg};
    assign q_b = ~exp_b;
    assign q_c = ~exp_c;

    // Model of instance A, driven by the cycle index within the run
    bit         m_valid = 1'b0;
    logic       m_busy, m_done, m_tclk, m_d;
    logic [2:0] m_exp;
    logic [7:0] m_pat;
    int         m_err, m_t;

    always @(posedge clk) begin : p_model
        int   nt, k, c;
        logic tn, dn;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_busy = 1'b0; m_done = 1'b0; m_tclk = 1'b0; m_d = 1'b0;
            m_exp = 3'b000; m_err = 0; m_t = 0; m_pat = '0;
        end else if (m_valid && m_busy) begin
            if ((m_t % DIV_A) == DIV_A - 1 && q_a != m_exp)
                m_err = (m_err < 255) ? m_err + 1 : 255;
            nt = m_t + 1;
            if (nt == int'(2 * PW_A * DIV_A)) begin
                tn = 1'b0; dn = m_d; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                k  = nt / DIV_A;
                c  = nt % DIV_A;
                tn = ((k % 2) == 1);
                dn = (c == DIV_A / 2) ? m_pat[k % PW_A] : m_d;
            end
            if (tn)            m_exp[2] = dn;
            if (!m_tclk && tn) m_exp[1] = dn;
            if (m_tclk && !tn) m_exp[0] = dn;
            m_tclk = tn; m_d = dn; m_t = nt;
        end else if (m_valid && m_done) begin
            m_done = 1'b0;
        end else if (m_valid && start_a) begin
            m_pat = pat_a; m_err = 0; m_busy = 1'b1; m_t = 0; m_tclk = 1'b0;
        end
    end

    always @(negedge clk) begin : p_compare
        if (m_valid) begin
            n_checks++;
            if ({tclk_a, d_a, exp_a, busy_a, done_a, err_a} !==
                {m_tclk, m_d, m_exp, m_busy, m_done, 8'(m_err)}) begin
                n_errors++;
                $display("FAIL model t=%0t got tclk=%b d=%b exp=%b busy=%b done=%b err=%0d want tclk=%b d=%b exp=%b busy=%b done=%b err=%0d",
                         $time, tclk_a, d_a, exp_a, busy_a, done_a, err_a,
                         m_tclk, m_d, m_exp, m_busy, m_done, m_err);
            end
        end
        if (done_a === 1'b1) done_cnt_a++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns at the negedge of run cycle 0 (busy has just risen)
    task automatic start_run(input int which, input logic [255:0] p);
        @(negedge clk);
        case (which)
            0: begin pat_a = p[7:0]; start_a = 1'b1; end
            1: begin pat_b = p[7:0]; start_b = 1'b1; end
            default: begin pat_c = p; start_c = 1'b1; end
        endcase
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic wait_done(input int which, input int restart_at,
                             output int len, output bit seen);
        logic b, dn;
        len  = 0;
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            case (which)
                0:       begin b = busy_a; dn = done_a; end
                1:       begin b = busy_b; dn = done_b; end
                default: begin b = busy_c; dn = done_c; end
            endcase
            if (dn === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (b === 1'b1) len++;
            if (which == 0)
                start_a = (restart_at >= 0) && (len == restart_at || len == restart_at + 1);
            @(negedge clk);
        end
        start_a = 1'b0;
        if (!seen) $display("FAIL timeout waiting for done on instance %0d", which);
    endtask

    initial begin : p_main
        int len, dc;
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_a", 32'({tclk_a, d_a, exp_a, busy_a, done_a, err_a}), 0);
        chk("reset_b", 32'({tclk_b, d_b, exp_b, busy_b, done_b, err_b}), 0);
        rst_n = 1'b1;

        // Ideal DUT, pattern A5
        dc = done_cnt_a;
        start_run(0, 256'hA5);
        wait_done(0, -1, len, seen);
        chk("a5_len", 32'(len), 64);
        chk("a5_seen", 32'(seen), 1);
        @(negedge clk);
        chk("a5_done_once", 32'(done_cnt_a - dc), 1);
        chk("a5_err", 32'(err_a), 0);

        // q stuck at 0, pattern FF: every compare from half-phase 1 on sees exp!=0
        do_reset();
        q_mode_a = 1;
        dc = done_cnt_a;
        start_run(0, 256'hFF);
        wait_done(0, -1, len, seen);
        chk("ff_len", 32'(len), 64);
        @(negedge clk);
        chk("ff_done_once", 32'(done_cnt_a - dc), 1);
        chk("ff_err", 32'(err_a), 15);
        repeat (3) @(negedge clk);
        chk("ff_err_hold", 32'(err_a), 15);
        q_mode_a = 0;

        // start re-pulsed while busy is ignored
        do_reset();
        dc = done_cnt_a;
        start_run(0, 256'h3C);
        wait_done(0, 10, len, seen);
        chk("restart_len", 32'(len), 64);
        @(negedge clk);
        chk("restart_done_once", 32'(done_cnt_a - dc), 1);

        // Reset mid-run at run cycle 20
        dc = done_cnt_a;
        start_run(0, 256'h5A);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", 32'({tclk_a, d_a, exp_a, busy_a, done_a, err_a}), 0);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt_a - dc), 0);
        chk("abort_idle", 32'(busy_a), 0);
        start_run(0, 256'h96);
        wait_done(0, -1, len, seen);
        chk("after_abort_len", 32'(len), 64);
        chk("after_abort_err", 32'(err_a), 0);

        // Latch vs FF, pattern 0000_0010
        do_reset();
        start_run(0, 256'h02);
        repeat (5) @(negedge clk);
        chk("lf_tclk_c5", 32'(tclk_a), 1);
        chk("lf_exp_c5", 32'(exp_a), 32'b000);
        @(negedge clk);
        chk("lf_exp_c6", 32'(exp_a), 32'b100);
        @(negedge clk);
        chk("lf_exp_c7", 32'(exp_a), 32'b100);
        @(negedge clk);
        chk("lf_exp_c8", 32'(exp_a), 32'b101);
        repeat (4) @(negedge clk);
        chk("lf_exp_c12", 32'(exp_a), 32'b001);
        repeat (4) @(negedge clk);
        chk("lf_exp_c16", 32'(exp_a), 32'b000);
        wait_done(0, -1, len, seen);
        chk("lf_seen", 32'(seen), 1);

        // DIV=2, stuck-inverse readback
        do_reset();
        start_run(1, 256'hC3);
        wait_done(1, -1, len, seen);
        chk("inv_len", 32'(len), 32);
        chk("inv_err", 32'(err_b), 16);

        // PAT_W=256, stuck-inverse readback saturates
        start_run(2, {8{$urandom}});
        wait_done(2, -1, len, seen);
        chk("sat_len", 32'(len), 1024);
        chk("sat_err", 32'(err_c), 255);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : p_watchdog
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/edge_stim_gen.md
EDGE_STIM_GEN -- requirements
Module: edge_stim_gen

Interface
REQ-001 Parameter DIV, default 4: clk cycles per tclk half-phase; legal range 2..255.
REQ-002 Parameter PAT_W, default 8: pattern length in bits.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to start a run, sampled each clk.
REQ-006 pattern  input  PAT_W  stimulus bits, captured on an accepted start.
REQ-007 q  input  3  DUT readback: q[2] D-latch, q[1] posedge FF, q[0] negedge FF.
REQ-008 tclk  output  1  generated test clock driven to the DUT.
REQ-009 d  output  1  generated test data driven to the DUT.
REQ-010 exp  output  3  model-expected value of q, same bit order as q.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 err_cnt  output  8  count of mismatching compares in the current/last run.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after the last half-phase; DONE->IDLE unconditionally after one cycle.
REQ-015 In IDLE, start=1 shall capture pattern, clear err_cnt, set busy the next cycle, and start half-phase 0 with tclk=0.
REQ-016 start shall be ignored while busy=1 or in DONE.
REQ-017 A run shall consist of 2*PAT_W half-phases of exactly DIV clk cycles each; tclk=0 in even half-phases, 1 in odd.
REQ-018 tclk shall toggle only at half-phase boundaries, registered, with no glitch.
REQ-019 d shall take pattern[k] (LSB first) at cycle DIV/2 (integer division) of half-phase k, and shall hold it until the next change.
REQ-020 The exp model shall be updated on the same clk edge as tclk/d: exp[2] follows d while tclk=1 and holds otherwise; exp[1] loads d on each 0->1 tclk transition; exp[0] loads d on each 1->0 tclk transition.
REQ-021 On the last cycle (cycle DIV-1) of every half-phase, q shall be compared with exp; each inequality shall increment err_cnt, saturating at 255.
REQ-022 After the final half-phase: tclk returns to 0, d holds, busy drops, done pulses for one cycle, and err_cnt holds until the next accepted start.
REQ-023 A run shall last 2*PAT_W*DIV cycles from busy rising to done.

Reset
REQ-024 With rst_n=0 at a clk edge, the block shall enter IDLE, and tclk, d, exp, busy, done and err_cnt shall all be 0.
REQ-025 Reset asserted mid-run shall abort the run without a done pulse; the run shall not resume.
REQ-026 If start and rst_n=0 coincide, reset shall win.

Structure
REQ-027 A shared package shall hold the FSM state enum and the q/exp bit-index constants (LATCH=2, POS=1, NEG=0).
REQ-028 The half-phase cycle counter and the half-phase index counter shall form one sub-module, phase_timer, which outputs mid, last and final_phase strobes.

Verification
REQ-029 Ideal DUT model (latch/posedge/negedge FFs on tclk,d), DIV=4, pattern=8'hA5 -> 16 half-phases, done after 64 cycles, err_cnt=0.
REQ-030 q tied to 3'b000, pattern=8'hFF -> err_cnt equals the count of compares with exp!=0 (nonzero, deterministic), done pulses once.
REQ-031 start pulsed again during busy -> ignored; run length is still 64 cycles, with a single done.
REQ-032 rst_n low at cycle 20 of a run -> next cycle all outputs are 0, and no done pulse occurs; a new start then runs normally.
REQ-033 DIV=2 and q forced to the inverse of exp -> err_cnt=16; with PAT_W=256 stuck-inverse -> err_cnt saturates at 255.
REQ-034 Latch vs. FF check, pattern=8'b0000_0010 -> exp[2] rises mid-high-phase 1, and exp[1]/exp[0] change only at tclk edges, as per REQ-020.
